// File: rtl/mux_n1_scan_pkg.sv
// rtl/mux_n1_scan_pkg.sv - shared encodings and width helpers for the N:1 scan mux
package mux_n1_scan_pkg;

   // mode input encodings
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // top-level FSM states
   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

   // index width for n channels; a lone channel still needs one bit
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // dwell counter width, wide enough to hold dwell itself so no count can overflow
   function automatic int cnt_width(input int dwell);
      return $clog2(dwell + 1);
   endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// rtl/mux_scan_counter.sv - dwell counter and rotating channel index for scan mode
module mux_scan_counter
   import mux_n1_scan_pkg::*;
#(
   parameter int N     = 4,
   parameter int DWELL = 10,
   parameter int SEL_W = sel_width(N),
   parameter int CNT_W = cnt_width(DWELL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [SEL_W-1:0] load_idx_i,
   input  logic             run_i,
   input  logic             hold_i,
   output logic [SEL_W-1:0] idx_nxt_o,
   output logic             wrap_nxt_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

   logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [SEL_W-1:0] scan_idx_q,  scan_idx_d;
   logic             wrap_d;

   // next count/index: load on scan entry, otherwise count unless frozen by hold
   always_comb begin
      dwell_cnt_d = dwell_cnt_q;
      scan_idx_d  = scan_idx_q;
      wrap_d      = 1'b0;
      if (load_i) begin
         scan_idx_d  = load_idx_i;
         dwell_cnt_d = '0;
      end else if (run_i && !hold_i) begin
         if (dwell_cnt_q == CNT_LAST) begin
            dwell_cnt_d = '0;
            // explicit compare keeps the index inside 0..N-1 for any N
            if (scan_idx_q == IDX_LAST) begin
               scan_idx_d = '0;
               wrap_d     = 1'b1;
            end else begin
               scan_idx_d = scan_idx_q + SEL_W'(1);
            end
         end else begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
         end
      end
   end

   // counter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt_q <= '0;
         scan_idx_q  <= '0;
      end else begin
         dwell_cnt_q <= dwell_cnt_d;
         scan_idx_q  <= scan_idx_d;
      end
   end

   // the top registers the upcoming index so out_sel matches the counter state it shows
   assign idx_nxt_o  = scan_idx_d;
   assign wrap_nxt_o = wrap_d;

endmodule

// File: rtl/mux_n1_scan.sv
// rtl/mux_n1_scan.sv - registered N:1 mux with manual select and dwell-based channel scan
module mux_n1_scan
   import mux_n1_scan_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int N     = 4,
   parameter  int DWELL = 10,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]   sel,
   input  logic               mode,
   input  logic               hold,
   output logic [WIDTH-1:0]   out,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_valid,
   output logic               out_changed,
   output logic               scan_wrap
);

   // N widened by one bit so it stays exact when N is a power of two
   localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [SEL_W-1:0]   out_sel_q, out_sel_d;
   logic               out_valid_q, out_valid_d;
   logic               out_changed_q, out_changed_d;
   logic               scan_wrap_q, scan_wrap_d;

   logic               sel_legal;
   logic               cnt_load;
   logic               cnt_run;
   logic [SEL_W-1:0]   scan_idx_nxt;
   logic               scan_wrap_nxt;

   // extract channel idx; loop form never indexes past the bus for illegal idx
   function automatic logic [WIDTH-1:0] pick_ch(input logic [N*WIDTH-1:0] bus,
                                                input logic [SEL_W-1:0]   idx);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   assign sel_legal = ({1'b0, sel} < N_EXT);

   // entering scan seeds the index from the channel currently shown
   assign cnt_load = (mode == MODE_SCAN) && (state_q == ST_MANUAL);
   assign cnt_run  = (mode == MODE_SCAN) && (state_q == ST_SCAN);

   mux_scan_counter #(
      .N     (N),
      .DWELL (DWELL),
      .SEL_W (SEL_W)
   ) u_scan_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_idx_i (out_sel_q),
      .run_i      (cnt_run),
      .hold_i     (hold),
      .idx_nxt_o  (scan_idx_nxt),
      .wrap_nxt_o (scan_wrap_nxt)
   );

   // next state and outputs; mode acts at the same edge it is sampled
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = 1'b0;
      scan_wrap_d = 1'b0;
      if (mode == MODE_SCAN) begin
         state_d     = ST_SCAN;
         out_sel_d   = scan_idx_nxt;
         out_d       = pick_ch(in_bus, scan_idx_nxt);
         out_valid_d = 1'b1;
         scan_wrap_d = scan_wrap_nxt;
      end else begin
         state_d = ST_MANUAL;
         // illegal sel keeps out/out_sel, so out_changed cannot fire
         if (sel_legal) begin
            out_sel_d   = sel;
            out_d       = pick_ch(in_bus, sel);
            out_valid_d = 1'b1;
         end
      end
      out_changed_d = (out_d != out_q);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_MANUAL;
         out_q         <= '0;
         out_sel_q     <= '0;
         out_valid_q   <= 1'b0;
         out_changed_q <= 1'b0;
         scan_wrap_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_q         <= out_d;
         out_sel_q     <= out_sel_d;
         out_valid_q   <= out_valid_d;
         out_changed_q <= out_changed_d;
         scan_wrap_q   <= scan_wrap_d;
      end
   end

   assign out         = out_q;
   assign out_sel     = out_sel_q;
   assign out_valid   = out_valid_q;
   assign out_changed = out_changed_q;
   assign scan_wrap   = scan_wrap_q;

endmodule

// File: tb/tb_mux_n1_scan.sv
// tb/tb_mux_n1_scan.sv - self-checking bench for mux_n1_scan
module tb_mux_n1_scan;

   localparam int N  = 4;
   localparam int DW = 3;

   logic        clk = 1'b0;
   logic        rst, mode, hold;
   logic [1:0]  sel;
   logic [31:0] in_bus;
   logic [23:0] in_bus3;

   logic [7:0]  out,  out3,  out1;
   logic [1:0]  out_sel, out_sel3, out_sel1;
   logic        out_valid, out_valid3, out_valid1;
   logic        out_changed, out_changed3, out_changed1;
   logic        scan_wrap, scan_wrap3, scan_wrap1;

   int total = 0;
   int bad   = 0;

   // reference model of the N=4, DWELL=3 instance
   logic [7:0]  m_out;
   int          m_sel;
   logic        m_valid, m_changed, m_wrap;
   bit          m_in_scan;
   int          m_start, m_pos;

   always #5 clk = ~clk;

   mux_n1_scan #(.WIDTH(8), .N(4), .DWELL(3)) dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .mode(mode), .hold(hold),
      .out(out), .out_sel(out_sel), .out_valid(out_valid),
      .out_changed(out_changed), .scan_wrap(scan_wrap));

   mux_n1_scan #(.WIDTH(8), .N(3), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .in_bus(in_bus3), .sel(sel), .mode(mode), .hold(hold),
      .out(out3), .out_sel(out_sel3), .out_valid(out_valid3),
      .out_changed(out_changed3), .scan_wrap(scan_wrap3));

   mux_n1_scan #(.WIDTH(8), .N(4), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .mode(mode), .hold(hold),
      .out(out1), .out_sel(out_sel1), .out_valid(out_valid1),
      .out_changed(out_changed1), .scan_wrap(scan_wrap1));

   // scan position counts non-held cycles since entry; channel = start + pos/DWELL mod N
   task automatic model_step();
      int         idx;
      logic [7:0] nv;
      bit         adv;
      if (rst) begin
         m_out = 8'h00; m_sel = 0; m_valid = 0; m_changed = 0; m_wrap = 0;
         m_in_scan = 0; m_start = 0; m_pos = 0;
      end else if (!mode) begin
         m_in_scan = 0;
         m_wrap    = 0;
         if (int'(sel) < N) begin
            nv = in_bus[int'(sel)*8 +: 8];
            m_sel = int'(sel);
            m_valid = 1;
         end else begin
            nv = m_out;
            m_valid = 0;
         end
         m_changed = (nv != m_out);
         m_out = nv;
      end else begin
         adv = 0;
         if (!m_in_scan) begin
            m_in_scan = 1; m_start = m_sel; m_pos = 0;
         end else if (!hold) begin
            m_pos++;
            adv = ((m_pos % DW) == 0);
         end
         idx = (m_start + m_pos / DW) % N;
         m_wrap = adv && (idx == 0);
         nv = in_bus[idx*8 +: 8];
         m_changed = (nv != m_out);
         m_out = nv;
         m_sel = idx;
         m_valid = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; mode = 0; hold = 0; sel = 2'd1;
      in_bus = 32'hA5A5_A5A5; in_bus3 = 24'h5A5A5A;
      tick(); tick();
      total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %0h want 0", out); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      total++; if (out_changed !== 1'b0) begin bad++; $display("FAIL reset_changed: got %0b want 0", out_changed); end
      total++; if (scan_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b want 0", scan_wrap); end
   endtask

   task automatic test_manual();
      rst = 0; mode = 0; hold = 0; in_bus = 32'h4433_2211; sel = 2'd2;
      tick();
      total++; if (out !== 8'h33) begin bad++; $display("FAIL manual_out: got %0h want 33", out); end
      total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL manual_sel: got %0d want 2", out_sel); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL manual_valid: got %0b want 1", out_valid); end
      total++; if (out_changed !== 1'b1) begin bad++; $display("FAIL manual_changed: got %0b want 1", out_changed); end
      tick();
      total++; if (out_changed !== 1'b0) begin bad++; $display("FAIL manual_changed_hold: got %0b want 0", out_changed); end
      total++; if (out !== 8'h33) begin bad++; $display("FAIL manual_out_hold: got %0h want 33", out); end
   endtask

   task automatic test_illegal();
      in_bus3 = 24'h33_2211; sel = 2'd1;
      tick();
      total++; if (out3 !== 8'h22) begin bad++; $display("FAIL illegal_pre_out: got %0h want 22", out3); end
      total++; if (out_valid3 !== 1'b1) begin bad++; $display("FAIL illegal_pre_valid: got %0b want 1", out_valid3); end
      sel = 2'd3;
      tick();
      total++; if (out3 !== 8'h22) begin bad++; $display("FAIL illegal_out: got %0h want 22", out3); end
      total++; if (out_sel3 !== 2'd1) begin bad++; $display("FAIL illegal_sel: got %0d want 1", out_sel3); end
      total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL illegal_valid: got %0b want 0", out_valid3); end
      total++; if (out_changed3 !== 1'b0) begin bad++; $display("FAIL illegal_changed: got %0b want 0", out_changed3); end
   endtask

   task automatic test_scan();
      int e, e1;
      mode = 0; sel = 2'd0; hold = 0; in_bus = 32'h4433_2211;
      tick();
      mode = 1;
      for (int i = 0; i < 13; i++) begin
         tick();
         e  = (i / DW) % N;
         e1 = i % N;
         total++; if (out_sel !== 2'(e)) begin bad++; $display("FAIL scan_sel[%0d]: got %0d want %0d", i, out_sel, e); end
         total++; if (out !== in_bus[e*8 +: 8]) begin bad++; $display("FAIL scan_out[%0d]: got %0h want %0h", i, out, in_bus[e*8 +: 8]); end
         total++; if (scan_wrap !== (i == 12)) begin bad++; $display("FAIL scan_wrap[%0d]: got %0b want %0b", i, scan_wrap, (i == 12)); end
         total++; if (out_sel1 !== 2'(e1)) begin bad++; $display("FAIL dwell1_sel[%0d]: got %0d want %0d", i, out_sel1, e1); end
         total++; if (out1 !== in_bus[e1*8 +: 8]) begin bad++; $display("FAIL dwell1_out[%0d]: got %0h want %0h", i, out1, in_bus[e1*8 +: 8]); end
         total++; if (scan_wrap1 !== (i > 0 && e1 == 0)) begin bad++; $display("FAIL dwell1_wrap[%0d]: got %0b want %0b", i, scan_wrap1, (i > 0 && e1 == 0)); end
      end
      mode = 0;
      tick();
   endtask

   task automatic test_hold();
      mode = 0; sel = 2'd0; hold = 0; in_bus = 32'h4433_2211;
      tick();
      mode = 1;
      for (int i = 0; i < 4; i++) tick();
      total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL hold_start_sel: got %0d want 1", out_sel); end
      hold = 1;
      for (int h = 0; h < 5; h++) begin
         if (h == 1) in_bus[15:8] = 8'h5A;
         tick();
         total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL hold_sel[%0d]: got %0d want 1", h, out_sel); end
         total++; if (out !== ((h >= 1) ? 8'h5A : 8'h22)) begin bad++; $display("FAIL hold_out[%0d]: got %0h", h, out); end
         total++; if (out_changed !== (h == 1)) begin bad++; $display("FAIL hold_changed[%0d]: got %0b want %0b", h, out_changed, (h == 1)); end
      end
      hold = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL release_sel[%0d]: got %0d want 1", i, out_sel); end
      end
      tick();
      total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL release_adv: got %0d want 2", out_sel); end
   endtask

   task automatic test_reset_mid();
      int n;
      mode = 1; hold = 0; n = 0;
      while (out_sel !== 2'd2 && n < 20) begin
         tick();
         n++;
      end
      total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL midrst_reach: got %0d want 2", out_sel); end
      rst = 1;
      tick();
      total++; if (out !== 8'h00) begin bad++; $display("FAIL midrst_out: got %0h want 0", out); end
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL midrst_sel: got %0d want 0", out_sel); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
      total++; if (out_changed !== 1'b0) begin bad++; $display("FAIL midrst_changed: got %0b want 0", out_changed); end
      total++; if (scan_wrap !== 1'b0) begin bad++; $display("FAIL midrst_wrap: got %0b want 0", scan_wrap); end
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (out_sel !== ((i < 3) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL midrst_resume[%0d]: got %0d", i, out_sel); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = (($urandom % 40) == 0);
         if (($urandom % 10) == 0) mode = ~mode;
         sel  = 2'($urandom % 4);
         hold = (($urandom % 4) == 0);
         if (($urandom % 3) == 0) in_bus[($urandom % 4)*8 +: 8] = 8'($urandom);
         tick();
         total++; if (out !== m_out) begin bad++; $display("FAIL rand_out[%0d]: got %0h want %0h", c, out, m_out); end
         total++; if (out_sel !== 2'(m_sel)) begin bad++; $display("FAIL rand_sel[%0d]: got %0d want %0d", c, out_sel, m_sel); end
         total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d]: got %0b want %0b", c, out_valid, m_valid); end
         total++; if (out_changed !== m_changed) begin bad++; $display("FAIL rand_changed[%0d]: got %0b want %0b", c, out_changed, m_changed); end
         total++; if (scan_wrap !== m_wrap) begin bad++; $display("FAIL rand_wrap[%0d]: got %0b want %0b", c, scan_wrap, m_wrap); end
      end
   endtask

   initial begin
      rst = 1; mode = 0; hold = 0; sel = 2'd0;
      in_bus = '0; in_bus3 = '0;
      m_out = '0; m_sel = 0; m_valid = 0; m_changed = 0; m_wrap = 0;
      m_in_scan = 0; m_start = 0; m_pos = 0;
      test_reset();
      test_manual();
      test_illegal();
      test_scan();
      test_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
